// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Sequential writeback stage for the NPC core. Selects the
//            writeback source (ALU, SNPC, load data, CSR read data). For loads
//            it waits on a memory read-response handshake, then extracts and
//            sign/zero-extends the data. Drives the register-file write port,
//            a per-instruction commit pulse, a misaligned-load flag and a
//            saturating load-wait cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int                XLEN           = 32,
  parameter int                CNT_W          = 32,
  parameter logic [XLEN-1:0]   DEFAULT_WBDATA = '0,
  localparam int               c_AL           = (XLEN == 64) ? 3 : 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // upstream instruction interface
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_wbsel,
  input  logic                 in_rf_wen,
  input  logic [4:0]           in_rd,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_snpc,
  input  logic [XLEN-1:0]      in_csr_rdata,
  input  logic [2:0]           in_ld_funct3,
  input  logic [c_AL-1:0]      in_ld_addr_lo,
  // memory read-response interface
  input  logic                 mem_rvalid,
  output logic                 mem_rready,
  input  logic [XLEN-1:0]      mem_rdata,
  // register-file write port and status
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 commit_valid,
  output logic                 ld_misalign,
  output logic [CNT_W-1:0]     ld_wait_cycles
);

  localparam logic       c_IS64    = (XLEN == 64);
  localparam logic [1:0] c_WB_ALU  = 2'd0;
  localparam logic [1:0] c_WB_SNPC = 2'd1;
  localparam logic [1:0] c_WB_LOAD = 2'd2;
  localparam logic [1:0] c_WB_CSR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  state_t            r_state;
  logic [4:0]        r_ld_rd;
  logic              r_ld_wen;
  logic [2:0]        r_ld_funct3;
  logic [c_AL-1:0]   r_ld_addr_lo;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic [XLEN-1:0]   w_src;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_ld_data;
  logic              w_ld_mis;

  // Handshake signals depend only on the current state
  assign in_ready       = (r_state != S_WAIT_MEM);
  assign mem_rready     = (r_state == S_WAIT_MEM);
  assign w_accept       = in_valid && in_ready;
  assign ld_wait_cycles = r_cnt;

  // Non-load writeback source select (LOAD never reaches this path)
  always_comb begin
    w_src = in_alu_result;
    case (in_wbsel)
      c_WB_ALU:  w_src = in_alu_result;
      c_WB_SNPC: w_src = in_snpc;
      c_WB_CSR:  w_src = in_csr_rdata;
      default:   w_src = in_alu_result;
    endcase
  end

  // Load data extraction, extension and alignment check from the captured load info
  always_comb begin
    w_lane    = mem_rdata >> {r_ld_addr_lo, 3'b000};
    w_ld_data = DEFAULT_WBDATA;
    w_ld_mis  = 1'b0;
    case (r_ld_funct3)
      3'd0: w_ld_data = XLEN'($signed(w_lane[7:0]));
      3'd1: begin
        w_ld_data = XLEN'($signed(w_lane[15:0]));
        w_ld_mis  = r_ld_addr_lo[0];
      end
      3'd2: begin
        w_ld_data = XLEN'($signed(w_lane[31:0]));
        w_ld_mis  = |r_ld_addr_lo[1:0];
      end
      3'd3: begin
        // LD only exists on a 64-bit datapath; otherwise treated as illegal
        if (c_IS64) begin
          w_ld_data = w_lane;
          w_ld_mis  = |r_ld_addr_lo;
        end
      end
      3'd4: w_ld_data = XLEN'(w_lane[7:0]);
      3'd5: begin
        w_ld_data = XLEN'(w_lane[15:0]);
        w_ld_mis  = r_ld_addr_lo[0];
      end
      3'd6: begin
        // LWU only exists on a 64-bit datapath; otherwise treated as illegal
        if (c_IS64) begin
          w_ld_data = XLEN'(w_lane[31:0]);
          w_ld_mis  = |r_ld_addr_lo[1:0];
        end
      end
      default: begin
        w_ld_data = DEFAULT_WBDATA;
        w_ld_mis  = 1'b0;
      end
    endcase
  end

  // Writeback FSM with registered commit outputs; rf_waddr/rf_wdata only move on a commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ld_rd      <= '0;
      r_ld_wen     <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_addr_lo <= '0;
      r_cnt        <= '0;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      commit_valid <= 1'b0;
      ld_misalign  <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      rf_wen       <= 1'b0;
      ld_misalign  <= 1'b0;
      case (r_state)
        S_WAIT_MEM: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (mem_rvalid) begin
            rf_waddr     <= r_ld_rd;
            rf_wdata     <= w_ld_data;
            rf_wen       <= r_ld_wen && (r_ld_rd != 5'd0) && !w_ld_mis;
            ld_misalign  <= w_ld_mis;
            commit_valid <= 1'b1;
            r_state      <= S_COMMIT;
          end
        end
        default: begin
          // IDLE and COMMIT both accept a new instruction
          if (w_accept) begin
            if (in_wbsel == c_WB_LOAD) begin
              r_ld_rd      <= in_rd;
              r_ld_wen     <= in_rf_wen;
              r_ld_funct3  <= in_ld_funct3;
              r_ld_addr_lo <= in_ld_addr_lo;
              r_state      <= S_WAIT_MEM;
            end else begin
              rf_waddr     <= in_rd;
              rf_wdata     <= w_src;
              rf_wen       <= in_rf_wen && (in_rd != 5'd0);
              commit_valid <= 1'b1;
              r_state      <= S_COMMIT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
